// File: rtl/div_unit_pkg.sv
// Shared pipeline definitions for the EX-stage iterative divider.
package div_unit_pkg;

   localparam int unsigned DIV_WIDTH  = 32;
   localparam int unsigned DIV_CYCLES = DIV_WIDTH;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on the {rem,quo} pair.
module div_step
   import div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_trial;

   // Partial remainder stays below the divisor, so the shifted value fits
   // WIDTH+1 bits and a kept trial result always fits WIDTH bits.
   always_comb begin
      w_shift = {i_rem, i_quo[WIDTH-1]};
      w_trial = {1'b0, w_shift} - {2'b00, i_divisor};
      if (w_trial[WIDTH+1]) begin
         o_rem = w_shift[WIDTH-1:0];
         o_quo = {i_quo[WIDTH-2:0], 1'b0};
      end else begin
         o_rem = w_trial[WIDTH-1:0];
         o_quo = {i_quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage; stalls the
// pipeline while busy and presents quotient (LO) / remainder (HI) in DONE.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             divE,
   input  logic             signedE,
   input  logic             annulE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   output logic             divstallE,
   output logic             divreadyE,
   output logic [WIDTH-1:0] hiE,
   output logic [WIDTH-1:0] loE
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   div_state_e       r_state;
   div_state_e       w_next;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_dividend;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_div0;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_ready;

   logic             w_start;
   logic             w_last;
   logic             w_finish;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH-1:0] w_step_rem;
   logic [WIDTH-1:0] w_step_quo;
   logic [WIDTH-1:0] w_lo_fin;
   logic [WIDTH-1:0] w_hi_fin;

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (r_divisor),
      .o_rem     (w_step_rem),
      .o_quo     (w_step_quo)
   );

   always_comb begin
      w_a_neg  = signedE & srcaE[WIDTH-1];
      w_b_neg  = signedE & srcbE[WIDTH-1];
      w_a_mag  = w_a_neg ? (~srcaE + 1'b1) : srcaE;
      w_b_mag  = w_b_neg ? (~srcbE + 1'b1) : srcbE;
      w_start  = (r_state == DIV_IDLE) & divE & ~annulE;
      w_last   = (r_count == CW'(WIDTH - 1));
      w_finish = (r_state == DIV_BUSY) & ~annulE & w_last;
   end

   // Final results are formed from the last step's output so they can be
   // registered on the edge entering DONE.
   always_comb begin
      if (r_div0) begin
         w_lo_fin = '1;
         w_hi_fin = r_dividend;
      end else begin
         w_lo_fin = r_neg_q ? (~w_step_quo + 1'b1) : w_step_quo;
         w_hi_fin = r_neg_r ? (~w_step_rem + 1'b1) : w_step_rem;
      end
   end

   always_comb begin
      w_next    = r_state;
      divstallE = 1'b0;
      case (r_state)
         DIV_IDLE: begin
            divstallE = divE & ~annulE;
            if (w_start) w_next = DIV_BUSY;
         end
         DIV_BUSY: begin
            divstallE = ~annulE;
            if (annulE)      w_next = DIV_IDLE;
            else if (w_last) w_next = DIV_DONE;
         end
         DIV_DONE: w_next = DIV_IDLE;
         default:  w_next = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= DIV_IDLE;
         r_count    <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_divisor  <= '0;
         r_dividend <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div0     <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_ready    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ready <= w_finish;
         case (r_state)
            DIV_IDLE: begin
               if (w_start) begin
                  r_count    <= '0;
                  r_rem      <= '0;
                  r_quo      <= w_a_mag;
                  r_divisor  <= w_b_mag;
                  r_dividend <= srcaE;
                  r_neg_q    <= w_a_neg ^ w_b_neg;
                  r_neg_r    <= w_a_neg;
                  r_div0     <= (srcbE == '0);
               end
            end
            DIV_BUSY: begin
               r_rem   <= w_step_rem;
               r_quo   <= w_step_quo;
               r_count <= r_count + CW'(1);
               if (w_finish) begin
                  r_lo <= w_lo_fin;
                  r_hi <= w_hi_fin;
               end
            end
            default: ;
         endcase
      end
   end

   assign divreadyE = r_ready;
   assign hiE       = r_hi;
   assign loE       = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at issue, compared on divreadyE.
module tb_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         divE;
   logic         signedE;
   logic         annulE;
   logic [W-1:0] srcaE;
   logic [W-1:0] srcbE;
   logic         divstallE;
   logic         divreadyE;
   logic [W-1:0] hiE;
   logic [W-1:0] loE;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   div_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .divE      (divE),
      .signedE   (signedE),
      .annulE    (annulE),
      .srcaE     (srcaE),
      .srcbE     (srcbE),
      .divstallE (divstallE),
      .divreadyE (divreadyE),
      .hiE       (hiE),
      .loE       (loE)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t e;
      if (b == '0) begin
         e.lo = '1;
         e.hi = a;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.lo = a;
         e.hi = '0;
      end else if (s) begin
         e.lo = $signed(a) / $signed(b);
         e.hi = $signed(a) % $signed(b);
      end else begin
         e.lo = a / b;
         e.hi = a % b;
      end
      return e;
   endfunction

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit track);
      divE    = 1'b1;
      signedE = s;
      annulE  = 1'b0;
      srcaE   = a;
      srcbE   = b;
      if (track) sb.push_back(model(a, b, s));
   endtask

   // Returns the number of negedges until divreadyE, or -1 on timeout.
   task automatic wait_ready(input int budget, output int n);
      n = -1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (divreadyE === 1'b1) begin
            n = k;
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; divE = 1'b0; signedE = 1'b0; annulE = 1'b0;
      srcaE = 32'h1234; srcbE = 32'd3;
      repeat (2) @(negedge clk);
      total++;
      if (divstallE !== 1'b0 || divreadyE !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags: stall=%b ready=%b, need 0/0", divstallE, divreadyE);
      end
      total++;
      if (hiE !== '0 || loE !== '0) begin
         bad++;
         $display("FAIL reset_hilo: hi=%h lo=%h, need 0/0", hiE, loE);
      end
      rst = 1'b0;
   endtask

   task automatic test_divu_basic();
      exp_t e;
      int   stall_bad = 0;
      @(negedge clk);
      issue(32'd100, 32'd7, 1'b0, 1'b1);
      #1;
      total++;
      if (divstallE !== 1'b1) begin
         bad++;
         $display("FAIL basic_start_stall: got %b need 1", divstallE);
      end
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (divstallE !== 1'b1 || divreadyE !== 1'b0) stall_bad++;
      end
      total++;
      if (stall_bad != 0) begin
         bad++;
         $display("FAIL basic_busy_stall: %0d bad cycles, need 0", stall_bad);
      end
      @(negedge clk);
      total++;
      if (divreadyE !== 1'b1 || divstallE !== 1'b0) begin
         bad++;
         $display("FAIL basic_done: ready=%b stall=%b, need 1/0", divreadyE, divstallE);
      end
      e = sb.pop_front();
      total++;
      if (loE !== e.lo || hiE !== e.hi) begin
         bad++;
         $display("FAIL basic_result: lo=%h hi=%h, need lo=%h hi=%h", loE, hiE, e.lo, e.hi);
      end
      divE = 1'b0;
      @(negedge clk);
      total++;
      if (divreadyE !== 1'b0) begin
         bad++;
         $display("FAIL basic_ready_pulse: ready=%b need 0", divreadyE);
      end
   endtask

   task automatic test_signed_and_zero();
      logic [W-1:0] ta[6] = '{32'hFFFF_FFF9, 32'd7,         32'h8000_0000, 32'd5, 32'hFFFF_FF9C, 32'hFFFF_FFF9};
      logic [W-1:0] tb[6] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0,         32'd2};
      logic         ts[6] = '{1'b1,          1'b1,          1'b1,          1'b0,  1'b1,          1'b0};
      exp_t e;
      int   n;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         issue(ta[i], tb[i], ts[i], 1'b1);
         wait_ready(40, n);
         total++;
         if (n !== 33) begin
            bad++;
            $display("FAIL latency_%0d: got %0d cycles need 33", i, n);
         end
         e = sb.pop_front();
         total++;
         if (loE !== e.lo || hiE !== e.hi) begin
            bad++;
            $display("FAIL result_%0d: lo=%h hi=%h, need lo=%h hi=%h", i, loE, hiE, e.lo, e.hi);
         end
         divE = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   n;
      @(negedge clk);
      issue(32'd20, 32'd3, 1'b0, 1'b1);
      wait_ready(40, n);
      e = sb.pop_front();
      total++;
      if (n !== 33 || loE !== e.lo || hiE !== e.hi) begin
         bad++;
         $display("FAIL b2b_first: n=%0d lo=%h hi=%h, need 33 lo=%h hi=%h", n, loE, hiE, e.lo, e.hi);
      end
      issue(32'd9, 32'd4, 1'b0, 1'b1);
      @(negedge clk);
      total++;
      if (divstallE !== 1'b1 || divreadyE !== 1'b0) begin
         bad++;
         $display("FAIL b2b_restart: stall=%b ready=%b, need 1/0", divstallE, divreadyE);
      end
      wait_ready(40, n);
      e = sb.pop_front();
      total++;
      if (n !== 33 || loE !== e.lo || hiE !== e.hi) begin
         bad++;
         $display("FAIL b2b_second: n=%0d lo=%h hi=%h, need 33 lo=%h hi=%h", n, loE, hiE, e.lo, e.hi);
      end
      divE = 1'b0;
      @(negedge clk);
      total++;
      if (divreadyE !== 1'b0 || sb.size() != 0) begin
         bad++;
         $display("FAIL b2b_drain: ready=%b pending=%0d, need 0/0", divreadyE, sb.size());
      end
   endtask

   task automatic test_annul();
      int seen = 0;
      @(negedge clk);
      issue(32'd50, 32'd5, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      annulE = 1'b1;
      #1;
      total++;
      if (divstallE !== 1'b0) begin
         bad++;
         $display("FAIL annul_stall: got %b need 0", divstallE);
      end
      @(negedge clk);
      annulE = 1'b0;
      divE   = 1'b0;
      #1;
      total++;
      if (divstallE !== 1'b0) begin
         bad++;
         $display("FAIL annul_idle: stall=%b need 0", divstallE);
      end
      @(negedge clk);
      divE   = 1'b1;
      annulE = 1'b1;
      #1;
      total++;
      if (divstallE !== 1'b0) begin
         bad++;
         $display("FAIL annul_idle_nostart: stall=%b need 0", divstallE);
      end
      @(negedge clk);
      divE   = 1'b0;
      annulE = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (divreadyE !== 1'b0 || divstallE !== 1'b0) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL annul_no_result: %0d active cycles, need 0", seen);
      end
   endtask

   task automatic test_rst_mid();
      int seen = 0;
      @(negedge clk);
      issue(32'd1000, 32'd7, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      rst  = 1'b1;
      divE = 1'b0;
      @(negedge clk);
      total++;
      if (divstallE !== 1'b0 || divreadyE !== 1'b0 || hiE !== '0 || loE !== '0) begin
         bad++;
         $display("FAIL rst_mid: stall=%b ready=%b hi=%h lo=%h, need all 0", divstallE, divreadyE, hiE, loE);
      end
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (divreadyE !== 1'b0) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL rst_abandon: ready seen %0d cycles, need 0", seen);
      end
   endtask

   task automatic test_operand_change();
      exp_t e;
      int   n = -1;
      @(negedge clk);
      issue(32'd1000, 32'd10, 1'b0, 1'b1);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (divreadyE === 1'b1) begin
            n = k;
            break;
         end
         srcaE   = $urandom;
         srcbE   = $urandom;
         signedE = 1'($urandom_range(0, 1));
      end
      e = sb.pop_front();
      total++;
      if (n !== 33 || loE !== e.lo || hiE !== e.hi) begin
         bad++;
         $display("FAIL operand_hold: n=%0d lo=%h hi=%h, need 33 lo=%h hi=%h", n, loE, hiE, e.lo, e.hi);
      end
      divE = 1'b0;
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_signed_and_zero();
      test_back_to_back();
      test_annul();
      test_rst_mid();
      test_operand_change();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
